// File: rtl/twos_comp_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : twos_comp_serial                                              |
// | Purpose  : LSB-first bit-serial pass / negate / abs / -abs unit with     |
// |            overflow and zero flags. Define TWOS_COMP_SAT_EN to saturate. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module twos_comp_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             busy
);

    localparam int                 c_cnt_w   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef TWOS_COMP_SAT_EN
    localparam logic [WIDTH-1:0]   c_max_pos = ~c_min_neg;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_data;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic               r_neg;
    logic               r_ovf_pend;
    logic               r_nz;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_out_ovf;
    logic               r_out_zero;
    logic               r_busy;

    logic               w_neg_in;
    logic               w_bit;
    logic               w_res_bit;
    logic               w_carry_nxt;
    logic               w_last;

    always_comb begin
        w_neg_in = 1'b0;
        case (in_mode)
            2'b00:   w_neg_in = 1'b0;
            2'b01:   w_neg_in = 1'b1;
            2'b10:   w_neg_in = in_data[WIDTH-1];
            default: w_neg_in = ~in_data[WIDTH-1];
        endcase
    end

    // Serial increment of the inverted operand: carry starts at 1 and dies at the first 1 bit.
    assign w_bit       = r_shift[0];
    assign w_res_bit   = r_neg ? (~w_bit ^ r_carry) : w_bit;
    assign w_carry_nxt = r_neg ? (~w_bit & r_carry) : r_carry;
    assign w_last      = (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf_pend  <= 1'b0;
            r_nz        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_zero  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_shift    <= in_data;
                        r_cnt      <= '0;
                        r_carry    <= 1'b1;
                        r_neg      <= w_neg_in;
                        r_ovf_pend <= w_neg_in && (in_data == c_min_neg);
                        r_nz       <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= r_shift >> 1;
                    r_data  <= {w_res_bit, r_data[WIDTH-1:1]};
                    r_carry <= w_carry_nxt;
                    r_nz    <= r_nz | w_res_bit;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out_ovf   <= r_ovf_pend;
                        r_out_zero  <= ~(r_nz | w_res_bit);
`ifdef TWOS_COMP_SAT_EN
                        if (r_ovf_pend) begin
                            r_data <= c_max_pos;
                        end
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_ovf   <= 1'b0;
                        r_out_zero  <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_data;
    assign out_ovf   = r_out_ovf;
    assign out_zero  = r_out_zero;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_twos_comp_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_twos_comp_serial                                           |
// | Purpose  : Scoreboard bench for twos_comp_serial at WIDTH 8, 2 and 32.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_twos_comp_serial;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        logic        zero;
    } exp_t;

    localparam logic [7:0] c_exp_min8 =
`ifdef TWOS_COMP_SAT_EN
        8'h7F;
`else
        8'h80;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n_x = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic       in_valid_8, in_ready_8, out_valid_8, out_ready_8, out_ovf_8, out_zero_8, busy_8;
    logic [7:0] in_data_8, out_data_8;
    logic [1:0] in_mode_8;
    logic        in_valid_2, in_ready_2, out_valid_2, out_ready_2, out_ovf_2, out_zero_2, busy_2;
    logic [1:0]  in_data_2, out_data_2;
    logic [1:0]  in_mode_2;
    logic        in_valid_32, in_ready_32, out_valid_32, out_ready_32, out_ovf_32, out_zero_32, busy_32;
    logic [31:0] in_data_32, out_data_32;
    logic [1:0]  in_mode_32;

    exp_t q8[$];
    exp_t q2[$];
    exp_t q32[$];
    int   last_acc8 = 0, last_acc2 = 0, last_acc32 = 0, spacing8 = 0;
    bit   have8 = 0, have2 = 0, have32 = 0;
    bit   rand_rdy8 = 0;
    bit   done_2 = 0, done_32 = 0;

    twos_comp_serial #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .in_data(in_data_8), .in_mode(in_mode_8), .out_valid(out_valid_8),
        .out_ready(out_ready_8), .out_data(out_data_8), .out_ovf(out_ovf_8),
        .out_zero(out_zero_8), .busy(busy_8)
    );
    twos_comp_serial #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n_x), .in_valid(in_valid_2), .in_ready(in_ready_2),
        .in_data(in_data_2), .in_mode(in_mode_2), .out_valid(out_valid_2),
        .out_ready(out_ready_2), .out_data(out_data_2), .out_ovf(out_ovf_2),
        .out_zero(out_zero_2), .busy(busy_2)
    );
    twos_comp_serial #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n_x), .in_valid(in_valid_32), .in_ready(in_ready_32),
        .in_data(in_data_32), .in_mode(in_mode_32), .out_valid(out_valid_32),
        .out_ready(out_ready_32), .out_data(out_data_32), .out_ovf(out_ovf_32),
        .out_zero(out_zero_32), .busy(busy_32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain modular arithmetic, independent of the serial datapath.
    function automatic exp_t model(input int w, input logic [31:0] d, input logic [1:0] m);
        exp_t        e;
        logic [31:0] mask, minv, x, r;
        logic        sgn, neg;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        minv = 32'd1 << (w - 1);
        x    = d & mask;
        sgn  = (x & minv) != 32'd0;
        case (m)
            2'b00:   neg = 1'b0;
            2'b01:   neg = 1'b1;
            2'b10:   neg = sgn;
            default: neg = ~sgn;
        endcase
        r     = neg ? ((32'd0 - x) & mask) : x;
        e.ovf = neg && (x == minv);
`ifdef TWOS_COMP_SAT_EN
        if (e.ovf) r = mask >> 1;
`endif
        e.data = r;
        e.zero = (r == 32'd0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid_8 && out_ready_8) begin
                if (q8.size() == 0) check("w8_spurious_result", 1, 0);
                else begin
                    e = q8.pop_front();
                    check("w8_data", out_data_8, e.data);
                    check("w8_ovf", out_ovf_8, e.ovf);
                    check("w8_zero", out_zero_8, e.zero);
                end
            end
            if (in_valid_8 && in_ready_8) begin
                if (have8) begin
                    spacing8 = cyc - last_acc8;
                    check("w8_spacing_ge", spacing8 >= 10, 1);
                end
                last_acc8 = cyc;
                have8 = 1;
                q8.push_back(model(8, {24'd0, in_data_8}, in_mode_8));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n_x) begin
            if (out_valid_2 && out_ready_2) begin
                if (q2.size() == 0) check("w2_spurious_result", 1, 0);
                else begin
                    e = q2.pop_front();
                    check("w2_data", out_data_2, e.data);
                    check("w2_ovf", out_ovf_2, e.ovf);
                    check("w2_zero", out_zero_2, e.zero);
                end
            end
            if (in_valid_2 && in_ready_2) begin
                if (have2) check("w2_spacing_ge", (cyc - last_acc2) >= 4, 1);
                last_acc2 = cyc;
                have2 = 1;
                q2.push_back(model(2, {30'd0, in_data_2}, in_mode_2));
            end
            if (out_valid_32 && out_ready_32) begin
                if (q32.size() == 0) check("w32_spurious_result", 1, 0);
                else begin
                    e = q32.pop_front();
                    check("w32_data", out_data_32, e.data);
                    check("w32_ovf", out_ovf_32, e.ovf);
                    check("w32_zero", out_zero_32, e.zero);
                end
            end
            if (in_valid_32 && in_ready_32) begin
                if (have32) check("w32_spacing_ge", (cyc - last_acc32) >= 34, 1);
                last_acc32 = cyc;
                have32 = 1;
                q32.push_back(model(32, in_data_32, in_mode_32));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy8) out_ready_8 = ($urandom % 3) != 0;
            out_ready_2  = ($urandom % 4) != 0;
            out_ready_32 = ($urandom % 3) != 0;
        end
    end

    function automatic logic [31:0] pick32();
        case ($urandom % 8)
            0:       return 32'h8000_0000;
            1:       return 32'h0;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Auxiliary widths: random operands, modes and backpressure.
    initial begin
        int k;
        in_valid_2 = 0; in_data_2 = 0; in_mode_2 = 0;
        in_valid_32 = 0; in_data_32 = 0; in_mode_32 = 0;
        repeat (3) @(posedge clk);
        #1 rst_n_x = 1;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    @(posedge clk); #1;
                    in_valid_2 = 1; in_data_2 = 2'($urandom); in_mode_2 = 2'($urandom);
                    k = 0;
                    @(negedge clk);
                    while (!in_ready_2 && k < 100) begin @(negedge clk); k++; end
                    if (k >= 100) check("w2_accept_timeout", 0, 1);
                end
                @(posedge clk); #1 in_valid_2 = 0;
            end
            begin
                for (int n = 0; n < 60; n++) begin
                    @(posedge clk); #1;
                    in_valid_32 = 1; in_data_32 = pick32(); in_mode_32 = 2'($urandom);
                    k = 0;
                    @(negedge clk);
                    while (!in_ready_32 && k < 300) begin @(negedge clk); k++; end
                    if (k >= 300) check("w32_accept_timeout", 0, 1);
                end
                @(posedge clk); #1 in_valid_32 = 0;
            end
        join
        k = 0;
        while ((q2.size() != 0 || q32.size() != 0) && k < 2000) begin @(negedge clk); k++; end
        check("aux_drain", q2.size() + q32.size(), 0);
        done_2 = 1;
        done_32 = 1;
    end

    task automatic op8(input logic [7:0] d, input logic [1:0] m, input int hold,
                       input logic [7:0] ed, input logic eo, input logic ez);
        int         lat;
        logic [7:0] held;
        @(posedge clk); #1;
        in_data_8 = d; in_mode_8 = m; in_valid_8 = 1; out_ready_8 = 0;
        @(negedge clk);
        check("w8_in_ready_idle", in_ready_8, 1);
        @(posedge clk); #1;
        in_valid_8 = 0; in_data_8 = ~d; in_mode_8 = ~m;
        lat = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end while (!out_valid_8 && lat < 40);
        check("w8_latency", lat, 8);
        check("w8_direct_data", out_data_8, ed);
        check("w8_direct_ovf", out_ovf_8, eo);
        check("w8_direct_zero", out_zero_8, ez);
        check("w8_done_in_ready", in_ready_8, 0);
        check("w8_done_busy", busy_8, 1);
        held = out_data_8;
        repeat (hold) begin
            @(negedge clk);
            check("w8_hold_valid", out_valid_8, 1);
            check("w8_hold_data", out_data_8, held);
            check("w8_hold_in_ready", in_ready_8, 0);
        end
        @(posedge clk); #1 out_ready_8 = 1;
        @(posedge clk); #1 out_ready_8 = 0;
        @(negedge clk);
        check("w8_back_idle_valid", out_valid_8, 0);
        check("w8_back_idle_ready", in_ready_8, 1);
    endtask

    initial begin
        int k;
        bit seen;
        in_valid_8 = 0; in_data_8 = 0; in_mode_8 = 0; out_ready_8 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready_8, 1);
        check("rst_out_valid", out_valid_8, 0);
        check("rst_busy", busy_8, 0);
        check("rst_out_data", out_data_8, 0);
        check("rst_out_ovf", out_ovf_8, 0);
        check("rst_out_zero", out_zero_8, 0);
        @(posedge clk); #1 rst_n = 1;

        op8(8'h05, 2'b01, 0, 8'hFB, 1'b0, 1'b0);
        op8(8'h80, 2'b01, 0, c_exp_min8, 1'b1, 1'b0);
        op8(8'hF6, 2'b10, 0, 8'h0A, 1'b0, 1'b0);
        op8(8'h0A, 2'b10, 0, 8'h0A, 1'b0, 1'b0);
        op8(8'h0A, 2'b11, 0, 8'hF6, 1'b0, 1'b0);
        op8(8'h3C, 2'b00, 0, 8'h3C, 1'b0, 1'b0);
        op8(8'h80, 2'b11, 0, 8'h80, 1'b0, 1'b0);
        op8(8'h00, 2'b01, 5, 8'h00, 1'b0, 1'b1);

        // Reset during the fourth SHIFT cycle discards the operation.
        @(posedge clk); #1;
        in_data_8 = 8'h05; in_mode_8 = 2'b01; in_valid_8 = 1;
        @(posedge clk); #1 in_valid_8 = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("midrst_in_ready", in_ready_8, 1);
        check("midrst_busy", busy_8, 0);
        check("midrst_out_valid", out_valid_8, 0);
        q8.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1; out_ready_8 = 1;
        seen = 0;
        repeat (20) begin @(negedge clk); seen |= out_valid_8; end
        check("midrst_no_result", seen, 0);
        @(posedge clk); #1 out_ready_8 = 0;
        op8(8'h01, 2'b01, 0, 8'hFF, 1'b0, 1'b0);

        // Back-to-back with out_ready held high.
        @(posedge clk); #1 out_ready_8 = 1;
        for (int n = 0; n < 3; n++) begin
            in_valid_8 = 1; in_data_8 = 8'(n + 3); in_mode_8 = 2'b01;
            k = 0;
            @(negedge clk);
            while (!in_ready_8 && k < 100) begin @(negedge clk); k++; end
            if (k >= 100) check("w8_b2b_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid_8 = 0;
        @(negedge clk);
        check("w8_b2b_spacing", spacing8, 10);
        k = 0;
        while (q8.size() != 0 && k < 100) begin @(negedge clk); k++; end
        check("w8_b2b_drain", q8.size(), 0);

        // Random operands and backpressure.
        rand_rdy8 = 1;
        for (int n = 0; n < 150; n++) begin
            @(posedge clk); #1;
            in_valid_8 = 1; in_data_8 = 8'($urandom); in_mode_8 = 2'($urandom);
            k = 0;
            @(negedge clk);
            while (!in_ready_8 && k < 100) begin @(negedge clk); k++; end
            if (k >= 100) check("w8_rand_timeout", 0, 1);
        end
        @(posedge clk); #1 in_valid_8 = 0;
        k = 0;
        while (q8.size() != 0 && k < 500) begin @(negedge clk); k++; end
        check("w8_rand_drain", q8.size(), 0);

        k = 0;
        while (!(done_2 && done_32) && k < 20000) begin @(posedge clk); k++; end
        check("aux_done", done_2 && done_32, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
